pointer_bank: RTL and testbench
===============================

# pointer_bank

Parametrised bank of NPTR address pointers with run-time selectable instruction-pointer (IP) and data-pointer (DP) roles, replacing the fixed two-register IP/DP swap pair. It drives the CPU address bus from the IP or the DP and exchanges the DP byte-wise with the 8-bit data bus. It also counts the IP and can retarget or swap roles on a clock edge.

## Interface
- NPTR, 4, number of pointer registers (2..8); SW = max(1, clog2(NPTR))
- AW, 16, pointer/address width, multiple of 8, 16..32; NB = AW/8, BW = max(1, clog2(NB))
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- di  in  8  data bus input
- byte_sel  in  BW  DP byte for we_n/oe_d_n (0 = LSB)
- oe_addr_ip_n  in  1  active-low: drive IP onto addr_out
- oe_addr_dp_n  in  1  active-low: drive DP onto addr_out
- oe_d_n  in  1  active-low: drive DP byte byte_sel onto data_out
- we_n  in  1  active-low: load di into DP byte byte_sel
- cnt_n  in  1  active-low: IP += 1
- set_sel_n  in  1  active-low: load role indices from ip_sel_in/dp_sel_in
- ip_sel_in  in  SW  new IP index
- dp_sel_in  in  SW  new DP index
- xchg_n  in  1  active-low: swap IP and DP indices
- dp_inc_n  in  1  active-low: DP += 1 (only with POINTER_BANK_DP_INC_EN)
- addr_out  out  AW  address bus, high-Z when not driven
- data_out  out  8  data bus, high-Z when not driven
- ip_idx  out  SW  current IP index
- dp_idx  out  SW  current DP index

## Operation
- State: ptr[0..NPTR-1] (AW bits each), ip_idx, dp_idx. Invariant ip_idx != dp_idx.
- Reset (rst=0, async): all ptr = 0, ip_idx = 0, dp_idx = 1, so addr_out and data_out are high-Z whenever their enables are deasserted.
- addr_out: ptr[ip_idx] if oe_addr_ip_n=0; else ptr[dp_idx] if oe_addr_dp_n=0; else Z. When both are asserted, IP wins (no contention).
- data_out: byte byte_sel of ptr[dp_idx] if oe_d_n=0, else Z. A byte_sel >= NB reads 0x00.
- we_n=0: ptr[dp_idx][8*byte_sel +: 8] <= di. A byte_sel >= NB is ignored.
- cnt_n=0: ptr[ip_idx] <= ptr[ip_idx] + 1 modulo 2^AW. All-ones wraps to 0.
- set_sel_n=0: ip_idx <= ip_sel_in and dp_idx <= dp_sel_in. The request is ignored (indices held) if ip_sel_in == dp_sel_in or if either value is >= NPTR.
- xchg_n=0 (set_sel_n=1): ip_idx <= dp_idx and dp_idx <= ip_idx.
- Simultaneous events at one edge:
  - Data ops (we, cnt, dp_inc) use the pre-edge indices.
  - set_sel has priority over xchg.
  - cnt and we target different registers by the invariant, so both take effect.
  - we and dp_inc in the same cycle: we wins and the increment is dropped.
- Non-selected pointers hold their value.

## Timing
- Outputs are combinational from registered state plus the enables. There is no cycle of read latency.
- All writes, counts and index changes take effect at the rising clk edge and are visible after it.
- A role change at edge N redirects addr_out/data_out from cycle N+1 onward.
- Asserting rst mid-cycle clears the state immediately. The first edge after rst deasserts performs normal operation.

## Configuration
- POINTER_BANK_DP_INC_EN defined: dp_inc_n is active. DP += 1 modulo 2^AW at the edge, with the we-priority rule above, giving post-increment data access.
- Not defined: the dp_inc_n port still exists but is ignored, and the DP changes only through we_n.

## Test plan
- Reset then idle, NPTR=4, AW=16 -> ip_idx=0, dp_idx=1, all ptr=0x0000; addr_out and data_out Z with all enables high.
- Load DP: we_n=0 with byte_sel=0, di=0x34, then byte_sel=1, di=0x12; then oe_addr_dp_n=0 -> addr_out=0x1234; oe_d_n=0, byte_sel=1 -> data_out=0x12.
- IP count and wrap: ptr[0]=0xFFFE, 3 edges with cnt_n=0 -> 0xFFFF, 0x0000, 0x0001; ptr[1] unchanged.
- Roles: xchg_n=0 -> ip_idx=1, dp_idx=0. set_sel_n=0 with ip_sel_in=2, dp_sel_in=2 -> indices unchanged. set_sel_n=0 with ip_sel_in=3, dp_sel_in=2 plus xchg_n=0 -> ip=3, dp=2.
- Same-edge xchg + cnt + we: ptr[0]=0x0010, ptr[1]=0x0000, di=0xAA, byte_sel=0 -> ptr[0]=0x0011, ptr[1]=0x00AA, indices swapped.
- With POINTER_BANK_DP_INC_EN: DP=0x00FF with dp_inc_n=0 -> 0x0100. dp_inc_n and we_n both 0 with di=0x55, byte_sel=0 -> DP=0x0155 (no increment). Async rst pulse mid-cycle -> all cleared immediately.

Source files
------------

// File: rtl/pointer_bank.sv
// pointer_bank: bank of NPTR address pointers with run-time selectable
// instruction-pointer (IP) and data-pointer (DP) roles.
//
// The IP or the DP drives the address bus. The DP is read and written one
// byte at a time over the 8-bit data bus. The IP can be counted, and the two
// roles can be reassigned (set_sel_n) or swapped (xchg_n) at a clock edge.
//
// Optional feature macro: POINTER_BANK_DP_INC_EN
//   defined     : dp_inc_n post-increments the DP (a write in the same cycle wins)
//   not defined : dp_inc_n is ignored
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   di            data bus input
//   byte_sel      DP byte for we_n / oe_d_n (0 = LSB); values >= NB are no-ops
//   oe_addr_ip_n  drive IP onto addr_out (wins over oe_addr_dp_n)
//   oe_addr_dp_n  drive DP onto addr_out
//   oe_d_n        drive DP byte byte_sel onto data_out
//   we_n          load di into DP byte byte_sel
//   cnt_n         IP += 1
//   set_sel_n     load roles from ip_sel_in / dp_sel_in (ignored if invalid)
//   ip_sel_in     new IP index
//   dp_sel_in     new DP index
//   xchg_n        swap IP and DP roles
//   dp_inc_n      DP += 1 (only with POINTER_BANK_DP_INC_EN)
//   addr_out      address bus, high-Z when not driven
//   data_out      data bus, high-Z when not driven
//   ip_idx        current IP index
//   dp_idx        current DP index
module pointer_bank #(
    parameter int unsigned NPTR = 4,
    parameter int unsigned AW   = 16,
    parameter int unsigned SW   = (NPTR > 1) ? $clog2(NPTR) : 1,
    parameter int unsigned NB   = AW / 8,
    parameter int unsigned BW   = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    di,
    input  logic [BW-1:0] byte_sel,
    input  logic          oe_addr_ip_n,
    input  logic          oe_addr_dp_n,
    input  logic          oe_d_n,
    input  logic          we_n,
    input  logic          cnt_n,
    input  logic          set_sel_n,
    input  logic [SW-1:0] ip_sel_in,
    input  logic [SW-1:0] dp_sel_in,
    input  logic          xchg_n,
    input  logic          dp_inc_n,
    output logic [AW-1:0] addr_out,
    output logic [7:0]    data_out,
    output logic [SW-1:0] ip_idx,
    output logic [SW-1:0] dp_idx
);

    logic [AW-1:0] ptr_q [NPTR];
    logic [AW-1:0] ptr_d [NPTR];
    logic [SW-1:0] ip_idx_q, ip_idx_d;
    logic [SW-1:0] dp_idx_q, dp_idx_d;

    logic          set_valid;
    logic [7:0]    dp_byte;

`ifndef POINTER_BANK_DP_INC_EN
    logic unused_dp_inc;
    assign unused_dp_inc = dp_inc_n;
`endif

    // A role load must keep the two roles on distinct, existing pointers.
    assign set_valid = (ip_sel_in != dp_sel_in) &&
                       (32'(ip_sel_in) < NPTR) &&
                       (32'(dp_sel_in) < NPTR);

    // Next state. Data ops address the pre-edge roles; cnt and we never
    // collide because IP and DP are always different registers.
    always_comb begin
        ptr_d    = ptr_q;
        ip_idx_d = ip_idx_q;
        dp_idx_d = dp_idx_q;

        if (!we_n) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (byte_sel == BW'(b)) begin
                    ptr_d[dp_idx_q][8*b +: 8] = di;
                end
            end
        end
`ifdef POINTER_BANK_DP_INC_EN
        else if (!dp_inc_n) begin
            ptr_d[dp_idx_q] = ptr_q[dp_idx_q] + AW'(1);
        end
`endif

        if (!cnt_n) begin
            ptr_d[ip_idx_q] = ptr_q[ip_idx_q] + AW'(1);
        end

        if (!set_sel_n) begin
            if (set_valid) begin
                ip_idx_d = ip_sel_in;
                dp_idx_d = dp_sel_in;
            end
        end else if (!xchg_n) begin
            ip_idx_d = dp_idx_q;
            dp_idx_d = ip_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '{default: '0};
            ip_idx_q <= SW'(0);
            dp_idx_q <= SW'(1);
        end else begin
            ptr_q    <= ptr_d;
            ip_idx_q <= ip_idx_d;
            dp_idx_q <= dp_idx_d;
        end
    end

    // Out-of-range byte selects read as zero.
    always_comb begin
        dp_byte = 8'h00;
        for (int b = 0; b < int'(NB); b++) begin
            if (byte_sel == BW'(b)) begin
                dp_byte = ptr_q[dp_idx_q][8*b +: 8];
            end
        end
    end

    assign addr_out = !oe_addr_ip_n ? ptr_q[ip_idx_q] :
                      !oe_addr_dp_n ? ptr_q[dp_idx_q] : {AW{1'bz}};
    assign data_out = !oe_d_n ? dp_byte : 8'hzz;

    assign ip_idx = ip_idx_q;
    assign dp_idx = dp_idx_q;

endmodule

// File: tb/tb_pointer_bank.sv
// tb_pointer_bank: directed plus random test of pointer_bank (NPTR=4, AW=16)
// against an arithmetic reference model of the pointer file and roles.
module tb_pointer_bank;

    localparam int unsigned NPTR = 4;
    localparam int unsigned AW   = 16;
    localparam int unsigned SW   = 2;
    localparam int unsigned NB   = 2;
    localparam int unsigned BW   = 1;
    localparam int unsigned MOD  = 65536;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    di;
    logic [BW-1:0] byte_sel;
    logic          oe_addr_ip_n, oe_addr_dp_n, oe_d_n;
    logic          we_n, cnt_n, set_sel_n, xchg_n, dp_inc_n;
    logic [SW-1:0] ip_sel_in, dp_sel_in;
    logic [AW-1:0] addr_out;
    logic [7:0]    data_out;
    logic [SW-1:0] ip_idx, dp_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    int unsigned m_ptr [NPTR];
    int unsigned m_ip, m_dp;

    pointer_bank #(.NPTR(NPTR), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .di           (di),
        .byte_sel     (byte_sel),
        .oe_addr_ip_n (oe_addr_ip_n),
        .oe_addr_dp_n (oe_addr_dp_n),
        .oe_d_n       (oe_d_n),
        .we_n         (we_n),
        .cnt_n        (cnt_n),
        .set_sel_n    (set_sel_n),
        .ip_sel_in    (ip_sel_in),
        .dp_sel_in    (dp_sel_in),
        .xchg_n       (xchg_n),
        .dp_inc_n     (dp_inc_n),
        .addr_out     (addr_out),
        .data_out     (data_out),
        .ip_idx       (ip_idx),
        .dp_idx       (dp_idx)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NPTR); i++) m_ptr[i] = 0;
        m_ip = 0;
        m_dp = 1;
    endtask

    // Apply the effect of one rising edge, using the inputs present at it.
    task automatic model_edge();
        int unsigned oip, odp, sh;
        oip = m_ip;
        odp = m_dp;
        if (!we_n) begin
            if (int'(byte_sel) < int'(NB)) begin
                sh = 8 * int'(byte_sel);
                m_ptr[odp] = (m_ptr[odp] & ~(32'hFF << sh)) | (32'(di) << sh);
            end
        end
`ifdef POINTER_BANK_DP_INC_EN
        else if (!dp_inc_n) begin
            m_ptr[odp] = (m_ptr[odp] + 1) % MOD;
        end
`endif
        if (!cnt_n) m_ptr[oip] = (m_ptr[oip] + 1) % MOD;
        if (!set_sel_n) begin
            if (ip_sel_in != dp_sel_in && int'(ip_sel_in) < int'(NPTR) &&
                int'(dp_sel_in) < int'(NPTR)) begin
                m_ip = ip_sel_in;
                m_dp = dp_sel_in;
            end
        end else if (!xchg_n) begin
            m_ip = odp;
            m_dp = oip;
        end
    endtask

    // Probe all outputs by toggling the output enables; restores them after.
    task automatic check_outputs(input string tag);
        logic [AW-1:0] zz_a;
        logic [7:0]    zz_d;
        logic [BW-1:0] bs_save;
        zz_a = 'z;
        zz_d = 'z;
        bs_save = byte_sel;
        chk({tag, "_ip_idx"}, 32'(ip_idx), m_ip);
        chk({tag, "_dp_idx"}, 32'(dp_idx), m_dp);
        oe_addr_ip_n = 1'b1; oe_addr_dp_n = 1'b1; oe_d_n = 1'b1;
        #1;
        chk({tag, "_addr_z"}, 32'(addr_out), 32'(zz_a));
        chk({tag, "_data_z"}, 32'(data_out), 32'(zz_d));
        oe_addr_ip_n = 1'b0;
        #1;
        chk({tag, "_addr_ip"}, 32'(addr_out), m_ptr[m_ip]);
        oe_addr_dp_n = 1'b0;
        #1;
        chk({tag, "_addr_both"}, 32'(addr_out), m_ptr[m_ip]);
        oe_addr_ip_n = 1'b1;
        #1;
        chk({tag, "_addr_dp"}, 32'(addr_out), m_ptr[m_dp]);
        oe_addr_dp_n = 1'b1;
        oe_d_n = 1'b0;
        for (int b = 0; b < int'(NB); b++) begin
            byte_sel = BW'(b);
            #1;
            chk({tag, "_data"}, 32'(data_out), (m_ptr[m_dp] >> (8 * b)) & 32'hFF);
        end
        oe_d_n = 1'b1;
        byte_sel = bs_save;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic wr(input logic [BW-1:0] bs, input logic [7:0] d);
        we_n = 1'b0;
        byte_sel = bs;
        di = d;
        cycle("wr");
        we_n = 1'b1;
    endtask

    task automatic peek_ip(output logic [AW-1:0] v);
        oe_addr_ip_n = 1'b0;
        #1;
        v = addr_out;
        oe_addr_ip_n = 1'b1;
    endtask

    task automatic peek_dp(output logic [AW-1:0] v);
        oe_addr_dp_n = 1'b0;
        #1;
        v = addr_out;
        oe_addr_dp_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] v;
        logic [AW-1:0] zz;
        zz = 'z;
        rst = 1'b0;
        di = 8'h00; byte_sel = '0;
        oe_addr_ip_n = 1'b1; oe_addr_dp_n = 1'b1; oe_d_n = 1'b1;
        we_n = 1'b1; cnt_n = 1'b1; set_sel_n = 1'b1; xchg_n = 1'b1; dp_inc_n = 1'b1;
        ip_sel_in = '0; dp_sel_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_addr_z", 32'(addr_out), 32'(zz));
        check_outputs("reset");
        cycle("idle");

        // Load the DP byte-wise
        wr(1'b0, 8'h34);
        wr(1'b1, 8'h12);
        @(negedge clk);
        peek_dp(v);
        chk("load_dp_addr", 32'(v), 32'h1234);
        oe_d_n = 1'b0; byte_sel = 1'b1;
        #1;
        chk("load_dp_data", 32'(data_out), 32'h12);
        oe_d_n = 1'b1;

        // Put 0xFFFE in ptr[0] through the DP role, then count it as IP
        xchg_n = 1'b0; cycle("xchg"); xchg_n = 1'b1;
        wr(1'b0, 8'hFE);
        wr(1'b1, 8'hFF);
        xchg_n = 1'b0; cycle("xchg"); xchg_n = 1'b1;
        cnt_n = 1'b0;
        cycle("cnt");
        @(negedge clk); peek_ip(v); chk("cnt_1", 32'(v), 32'hFFFF);
        cycle("cnt");
        @(negedge clk); peek_ip(v); chk("cnt_wrap", 32'(v), 32'h0000);
        cycle("cnt");
        @(negedge clk); peek_ip(v); chk("cnt_3", 32'(v), 32'h0001);
        cnt_n = 1'b1;
        peek_dp(v); chk("cnt_dp_held", 32'(v), 32'h1234);

        // Role changes
        xchg_n = 1'b0; cycle("xchg"); xchg_n = 1'b1;
        chk("xchg_ip", 32'(ip_idx), 1); chk("xchg_dp", 32'(dp_idx), 0);
        set_sel_n = 1'b0; ip_sel_in = 2'd2; dp_sel_in = 2'd2;
        cycle("set_bad");
        chk("set_bad_ip", 32'(ip_idx), 1); chk("set_bad_dp", 32'(dp_idx), 0);
        ip_sel_in = 2'd3; xchg_n = 1'b0;
        cycle("set_pri");
        set_sel_n = 1'b1; xchg_n = 1'b1;
        chk("set_pri_ip", 32'(ip_idx), 3); chk("set_pri_dp", 32'(dp_idx), 2);

        // Same-edge xchg + cnt + we
        set_sel_n = 1'b0; ip_sel_in = 2'd1; dp_sel_in = 2'd0; cycle("set"); set_sel_n = 1'b1;
        wr(1'b0, 8'h10);
        wr(1'b1, 8'h00);
        set_sel_n = 1'b0; ip_sel_in = 2'd0; dp_sel_in = 2'd1; cycle("set"); set_sel_n = 1'b1;
        wr(1'b0, 8'h00);
        wr(1'b1, 8'h00);
        xchg_n = 1'b0; cnt_n = 1'b0; we_n = 1'b0; di = 8'hAA; byte_sel = 1'b0;
        cycle("combo");
        xchg_n = 1'b1; cnt_n = 1'b1; we_n = 1'b1;
        @(negedge clk);
        chk("combo_ip", 32'(ip_idx), 1); chk("combo_dp", 32'(dp_idx), 0);
        peek_ip(v); chk("combo_ptr1", 32'(v), 32'h00AA);
        peek_dp(v); chk("combo_ptr0", 32'(v), 32'h0011);

`ifdef POINTER_BANK_DP_INC_EN
        wr(1'b0, 8'hFF);
        wr(1'b1, 8'h00);
        dp_inc_n = 1'b0; cycle("dpinc");
        @(negedge clk); peek_dp(v); chk("dpinc_carry", 32'(v), 32'h0100);
        we_n = 1'b0; di = 8'h55; byte_sel = 1'b0; cycle("dpinc_we");
        dp_inc_n = 1'b1; we_n = 1'b1;
        @(negedge clk); peek_dp(v); chk("dpinc_we_wins", 32'(v), 32'h0155);
`endif

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ip", 32'(ip_idx), 0);
        chk("arst_dp", 32'(dp_idx), 1);
        peek_ip(v); chk("arst_ptr0", 32'(v), 32'h0000);
        peek_dp(v); chk("arst_ptr1", 32'(v), 32'h0000);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            we_n      = ($urandom_range(0, 3) != 0);
            cnt_n     = ($urandom_range(0, 2) != 0);
            set_sel_n = ($urandom_range(0, 4) != 0);
            xchg_n    = ($urandom_range(0, 3) != 0);
            dp_inc_n  = ($urandom_range(0, 2) != 0);
            ip_sel_in = SW'($urandom_range(0, NPTR - 1));
            dp_sel_in = SW'($urandom_range(0, NPTR - 1));
            di        = 8'($urandom);
            byte_sel  = BW'($urandom_range(0, NB - 1));
            cycle("rand");
        end
        we_n = 1'b1; cnt_n = 1'b1; set_sel_n = 1'b1; xchg_n = 1'b1; dp_inc_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
